// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: selection, coin credit, dispense/refund and change.
// Optional PAY inactivity timeout is compiled in with `define VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int unsigned PRICE0         = 5,
  parameter int unsigned PRICE1         = 8,
  parameter int unsigned PRICE2         = 12,
  parameter int unsigned PRICE3         = 25,
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       sel_vld,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       cancel,
  output logic [4:0] price,
  output logic [4:0] change,
  output logic       dispense,
  output logic       refund,
  output logic       coin_rej,
  output logic       busy
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StPay, StShow} state_e;

  state_e           state_q, state_d;
  logic [4:0]       credit_q, credit_d;
  logic [4:0]       price_q, price_d;
  logic [4:0]       change_q, change_d;
  logic             dispense_q, dispense_d;
  logic             refund_q, refund_d;
  logic             coin_rej_q, coin_rej_d;
  logic             busy_q, busy_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic [5:0] coin_sum;
  logic [5:0] total;
  logic       any_coin;
  logic [4:0] sel_price;
  logic       timeout;
  logic       coin_taken;

  assign any_coin = coin_1 | coin_5 | coin_10;
  assign coin_sum = 6'(coin_1) + (coin_5 ? 6'd5 : 6'd0) + (coin_10 ? 6'd10 : 6'd0);
  assign total    = {1'b0, credit_q} + coin_sum;

  always_comb begin
    sel_price = 5'(PRICE0);
    unique case (sel)
      2'd0: sel_price = 5'(PRICE0);
      2'd1: sel_price = 5'(PRICE1);
      2'd2: sel_price = 5'(PRICE2);
      2'd3: sel_price = 5'(PRICE3);
      default: sel_price = 5'(PRICE0);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    price_d    = price_q;
    change_d   = change_q;
    dispense_d = 1'b0;
    refund_d   = 1'b0;
    coin_rej_d = 1'b0;
    hold_d     = '0;
    coin_taken = 1'b0;
    unique case (state_q)
      StIdle: begin
        coin_rej_d = any_coin;
        if (sel_vld) begin
          price_d  = sel_price;
          credit_d = 5'd0;
          change_d = 5'd0;
          state_d  = StPay;
        end
      end
      StPay: begin
        if (cancel || timeout) begin
          refund_d   = 1'b1;
          change_d   = credit_q;
          price_d    = 5'd0;
          coin_rej_d = any_coin;
          state_d    = StShow;
        end else if (total > 6'd31) begin
          // Overflowing credit: bounce the whole cycle's coins.
          coin_rej_d = 1'b1;
        end else if (total >= {1'b0, price_q}) begin
          dispense_d = 1'b1;
          change_d   = 5'(total - {1'b0, price_q});
          state_d    = StShow;
        end else begin
          credit_d   = total[4:0];
          change_d   = total[4:0];
          coin_taken = any_coin;
        end
      end
      StShow: begin
        coin_rej_d = any_coin;
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d  = StIdle;
          price_d  = 5'd0;
          change_d = 5'd0;
          credit_d = 5'd0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_q, to_d;

  assign timeout = (state_q == StPay) && (to_q == ToW'(TIMEOUT_CYCLES - 1));

  // Restarts on PAY entry and on every accepted coin.
  always_comb begin
    to_d = '0;
    if (state_q == StPay && state_d == StPay && !coin_taken) begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, coin_taken};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      credit_q   <= 5'd0;
      price_q    <= 5'd0;
      change_q   <= 5'd0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      price_q    <= price_d;
      change_q   <= change_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
      coin_rej_q <= coin_rej_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
    end
  end

  assign price    = price_q;
  assign change   = change_q;
  assign dispense = dispense_q;
  assign refund   = refund_q;
  assign coin_rej = coin_rej_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios then random traffic against a
// cycle-level behavioural model of the vending transaction rules.
module tb_vend_ctrl;

  localparam int unsigned Hold = 4;
  localparam int unsigned Tmo  = 16;
`ifdef VEND_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       sel_vld, coin_1, coin_5, coin_10, cancel;
  logic [4:0] price, change;
  logic       dispense, refund, coin_rej, busy;

  vend_ctrl #(
    .PRICE0        (5),
    .PRICE1        (8),
    .PRICE2        (12),
    .PRICE3        (25),
    .HOLD_CYCLES   (Hold),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .sel_vld (sel_vld),
    .coin_1  (coin_1),
    .coin_5  (coin_5),
    .coin_10 (coin_10),
    .cancel  (cancel),
    .price   (price),
    .change  (change),
    .dispense(dispense),
    .refund  (refund),
    .coin_rej(coin_rej),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 = waiting for a selection, 1 = collecting coins, 2 = showing result.
  int prices[4] = '{5, 8, 12, 25};
  int m_phase, m_credit, m_price, m_change, m_show_left, m_quiet;
  bit m_disp, m_ref, m_rej;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
               $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit sv, input int s, input bit c1,
                                     input bit c5, input bit c10, input bit cn);
    int sum;
    bit coin;
    sum    = int'(c1) + 5 * int'(c5) + 10 * int'(c10);
    coin   = c1 | c5 | c10;
    m_disp = 0;
    m_ref  = 0;
    m_rej  = 0;
    if (r) begin
      m_phase  = 0;
      m_credit = 0;
      m_price  = 0;
      m_change = 0;
      m_quiet  = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_rej = coin;
        if (sv) begin
          m_price  = prices[s];
          m_credit = 0;
          m_change = 0;
          m_quiet  = 0;
          m_phase  = 1;
        end
      end
      1: begin
        if (cn || (TmoEn && m_quiet + 1 >= int'(Tmo))) begin
          m_ref       = 1;
          m_rej       = coin;
          m_change    = m_credit;
          m_price     = 0;
          m_phase     = 2;
          m_show_left = Hold;
        end else if (m_credit + sum > 31) begin
          m_rej = 1;
          m_quiet++;
        end else if (m_credit + sum >= m_price) begin
          m_disp      = 1;
          m_change    = m_credit + sum - m_price;
          m_phase     = 2;
          m_show_left = Hold;
        end else begin
          m_credit += sum;
          m_change = m_credit;
          if (sum > 0) m_quiet = 0;
          else m_quiet++;
        end
      end
      default: begin
        m_rej = coin;
        m_show_left--;
        if (m_show_left == 0) begin
          m_phase  = 0;
          m_price  = 0;
          m_change = 0;
          m_credit = 0;
        end
      end
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, compare every output after the edge.
  task automatic step(input bit r, input bit sv, input int s, input bit c1, input bit c5,
                      input bit c10, input bit cn);
    rst     = r;
    sel_vld = sv;
    sel     = 2'(s);
    coin_1  = c1;
    coin_5  = c5;
    coin_10 = c10;
    cancel  = cn;
    @(posedge clk);
    model_step(r, sv, s, c1, c5, c10, cn);
    #1;
    check("outputs", {18'd0, price, change, dispense, refund, coin_rej, busy},
          {18'd0, 5'(m_price), 5'(m_change), m_disp, m_ref, m_rej, (m_phase != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_phase = 0; m_credit = 0; m_price = 0; m_change = 0; m_show_left = 0; m_quiet = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_busy", busy, 0);

    // Product 1, coins 5,1,5 -> dispense with change 3, back to idle after the hold.
    step(0, 1, 1, 0, 0, 0, 0);
    check("p1_price", price, 8);
    step(0, 0, 0, 0, 1, 0, 0);
    check("p1_credit5", change, 5);
    step(0, 0, 0, 1, 0, 0, 0);
    check("p1_credit6", change, 6);
    step(0, 0, 0, 0, 1, 0, 0);
    check("p1_dispense", dispense, 1);
    check("p1_change", change, 3);
    idle(3);
    check("p1_hold_busy", busy, 1);
    idle(1);
    check("p1_idle_busy", busy, 0);
    check("p1_idle_price", price, 0);

    // Simultaneous coins summed.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("p0_dispense", dispense, 1);
    check("p0_change", change, 1);
    idle(Hold);

    // Overflow rejection keeps credit.
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("p3_credit20", change, 20);
    step(0, 0, 0, 0, 1, 1, 0);
    check("p3_rej", coin_rej, 1);
    check("p3_keep20", change, 20);
    step(0, 0, 0, 0, 1, 0, 0);
    check("p3_dispense", dispense, 1);
    check("p3_change0", change, 0);
    idle(Hold);

    // Cancel with a coin in the same cycle.
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    check("p2_refund", refund, 1);
    check("p2_rej", coin_rej, 1);
    check("p2_change", change, 10);
    check("p2_price", price, 0);
    check("p2_nodisp", dispense, 0);
    idle(Hold);

    // Reset mid-transaction with credit 7.
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("rst_credit7", change, 7);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_busy", busy, 0);
    check("rst_change", change, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("rst_rej", coin_rej, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    check("rst_credit0", change, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("rst_dispense", dispense, 1);
    check("rst_change2", change, 2);
    idle(Hold);

    // Inactivity in PAY.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(Tmo);
    check("tmo_refund", refund, 32'(TmoEn));
    check("tmo_busy", busy, 1);
    check("tmo_change", change, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(Hold + 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3, int'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
